// File: rtl/bsram_memory_adapter.sv
// rtl/bsram_memory_adapter.sv - byte/half/word memory-bus slave in front of a single-port 32-bit Gowin BSRAM
module bsram_memory_adapter #(
    parameter int ADDRESS_SIZE     = 15,
    parameter int RAM_ADDRESS_SIZE = 11,
    parameter int READ_LATENCY     = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        strobe,
    input  logic [ADDRESS_SIZE-1:0]     address,
    input  logic [1:0]                  size,
    input  logic                        writeEnable,
    input  logic [31:0]                 dataWrite,
    output logic [31:0]                 dataRead,
    output logic                        ready,
    output logic                        error,
    output logic [RAM_ADDRESS_SIZE-1:0] ramAddress,
    output logic [31:0]                 ramDataIn,
    input  logic [31:0]                 ramDataOut,
    output logic                        ramCe,
    output logic                        ramWre,
    output logic                        ramOce,
    output logic                        ramReset
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WRITE     = 3'd1;
    localparam logic [2:0] READ_WAIT = 3'd2;
    localparam logic [2:0] MERGE     = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    // READ_WAIT spans the issue cycle plus READ_LATENCY cycles; data is taken on the last one.
    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY);

    logic [2:0]  state;
    logic [1:0]  wait_count;
    logic [1:0]  lane;
    logic [1:0]  size_q;
    logic        store_q;
    logic [15:0] store_low;
    logic        error_q;

    logic        out_of_range;
    logic        request_error;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] merged;

    generate
        if (ADDRESS_SIZE - 2 > RAM_ADDRESS_SIZE) begin : g_range
            assign out_of_range = |address[ADDRESS_SIZE-1:RAM_ADDRESS_SIZE+2];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign request_error = (size == 2'd3)
                         | ((size == 2'd1) & address[0])
                         | ((size == 2'd2) & (|address[1:0]))
                         | out_of_range;

    assign shifted = ramDataOut >> {lane, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    load_data = {24'b0, shifted[7:0]};
            2'd1:    load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        merged = ramDataOut;
        if (size_q == 2'd0) begin
            merged[{lane, 3'b000} +: 8] = store_low[7:0];
        end else begin
            merged[{lane[1], 4'b0000} +: 16] = store_low;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_count <= 2'd0;
            lane       <= 2'd0;
            size_q     <= 2'd0;
            store_q    <= 1'b0;
            store_low  <= 16'd0;
            error_q    <= 1'b0;
            dataRead   <= 32'd0;
            ramAddress <= '0;
            ramDataIn  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe) begin
                        lane       <= address[1:0];
                        size_q     <= size;
                        store_q    <= writeEnable;
                        store_low  <= dataWrite[15:0];
                        error_q    <= request_error;
                        ramAddress <= address[RAM_ADDRESS_SIZE+1:2];
                        ramDataIn  <= dataWrite;
                        wait_count <= 2'd0;
                        if (request_error) begin
                            state <= DONE;
                        end else if (writeEnable && size == 2'd2) begin
                            state <= WRITE;
                        end else begin
                            state <= READ_WAIT;
                        end
                    end
                end
                WRITE: state <= DONE;
                READ_WAIT: begin
                    if (wait_count == LAST_WAIT) begin
                        if (store_q) begin
                            ramDataIn <= merged;
                            state     <= MERGE;
                        end else begin
                            dataRead <= load_data;
                            state    <= DONE;
                        end
                    end else begin
                        wait_count <= wait_count + 2'd1;
                    end
                end
                MERGE: state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready    = (state == DONE);
    assign error    = (state == DONE) & error_q;
    assign ramCe    = (state == WRITE) | (state == MERGE)
                    | ((state == READ_WAIT) & (wait_count == 2'd0));
    assign ramWre   = (state == WRITE) | (state == MERGE);
    assign ramOce   = 1'b1;
    assign ramReset = 1'b0;

endmodule

// File: tb/tb_bsram_memory_adapter.sv
// tb/tb_bsram_memory_adapter.sv - directed-vector bench for bsram_memory_adapter with an output-register BSRAM model
module tb_bsram_memory_adapter;

    logic        clock;
    logic        reset;
    logic        strobe;
    logic [14:0] address;
    logic [1:0]  size;
    logic        writeEnable;
    logic [31:0] dataWrite;
    logic [31:0] dataRead;
    logic        ready;
    logic        error;
    logic [10:0] ramAddress;
    logic [31:0] ramDataIn;
    logic [31:0] ramDataOut;
    logic        ramCe;
    logic        ramWre;
    logic        ramOce;
    logic        ramReset;

    int vectors     = 0;
    int miscompares = 0;

    bsram_memory_adapter #(
        .ADDRESS_SIZE(15), .RAM_ADDRESS_SIZE(11), .READ_LATENCY(2)
    ) dut (
        .clock(clock), .reset(reset), .strobe(strobe), .address(address),
        .size(size), .writeEnable(writeEnable), .dataWrite(dataWrite),
        .dataRead(dataRead), .ready(ready), .error(error),
        .ramAddress(ramAddress), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut),
        .ramCe(ramCe), .ramWre(ramWre), .ramOce(ramOce), .ramReset(ramReset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BSRAM in output-register mode: array read stage then an always-enabled output register.
    logic [31:0] mem [0:2047];
    logic [31:0] rd_stage;
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        rd_stage   = 32'd0;
        ramDataOut = 32'd0;
    end
    always @(posedge clock) begin
        if (ramCe) begin
            if (ramWre) mem[ramAddress] <= ramDataIn;
            else        rd_stage        <= mem[ramAddress];
        end
        ramDataOut <= rd_stage;
    end

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge with the DUT idle; that cycle is cycle 0.
    task automatic do_request(input logic we, input logic [1:0] sz, input logic [14:0] addr,
                              input logic [31:0] wd, output int rdy_cycle, output logic err,
                              output logic ce_seen);
        strobe = 1'b1; writeEnable = we; size = sz; address = addr; dataWrite = wd;
        rdy_cycle = -1; err = 1'b0; ce_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (ramCe) ce_seen = 1'b1;
            if (ready) begin
                rdy_cycle = c;
                err = error;
            end
            @(posedge clock); #1;
            if (c == 0) begin
                strobe = 1'b0; address = 15'h5555; size = 2'd3;
                writeEnable = ~we; dataWrite = ~wd;
            end
            if (rdy_cycle >= 0) break;
        end
    endtask

    int          rc;
    logic        er;
    logic        ce;
    int          ready_at [0:2];
    logic [31:0] data_at  [0:2];
    int          n_ready;

    initial begin
        reset = 1'b1; strobe = 1'b0; address = '0; size = 2'd0;
        writeEnable = 1'b0; dataWrite = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check_value("reset_ready", {31'd0, ready}, 32'd0);
        check_value("reset_error", {31'd0, error}, 32'd0);
        check_value("reset_ce_wre", {30'd0, ramCe, ramWre}, 32'd0);
        check_value("reset_dataread", dataRead, 32'd0);
        check_value("reset_ramaddr", {21'd0, ramAddress}, 32'd0);
        check_value("reset_ramdin", ramDataIn, 32'd0);
        check_value("oce_reset_consts", {30'd0, ramOce, ramReset}, 32'd2);
        reset = 1'b0;

        do_request(1'b1, 2'd2, 15'h0010, 32'hDEADBEEF, rc, er, ce);
        check_value("wstore_ready_cycle", 32'(rc), 32'd2);
        check_value("wstore_error", {31'd0, er}, 32'd0);
        check_value("wstore_mem", mem[4], 32'hDEADBEEF);
        do_request(1'b0, 2'd2, 15'h0010, 32'h0, rc, er, ce);
        check_value("wload_ready_cycle", 32'(rc), 32'd4);
        check_value("wload_error", {31'd0, er}, 32'd0);
        check_value("wload_data", dataRead, 32'hDEADBEEF);

        do_request(1'b1, 2'd2, 15'h0010, 32'h11223344, rc, er, ce);
        do_request(1'b1, 2'd0, 15'h0013, 32'hFFFFFF5A, rc, er, ce);
        check_value("bstore_ready_cycle", 32'(rc), 32'd5);
        check_value("bstore_mem", mem[4], 32'h5A223344);
        do_request(1'b0, 2'd2, 15'h0010, 32'h0, rc, er, ce);
        check_value("bstore_readback", dataRead, 32'h5A223344);
        do_request(1'b0, 2'd1, 15'h0012, 32'h0, rc, er, ce);
        check_value("hload_data", dataRead, 32'h00005A22);
        do_request(1'b0, 2'd0, 15'h0011, 32'h0, rc, er, ce);
        check_value("bload_ready_cycle", 32'(rc), 32'd4);
        check_value("bload_data", dataRead, 32'h00000033);
        do_request(1'b1, 2'd1, 15'h0016, 32'hFFFFBEEF, rc, er, ce);
        check_value("hstore_mem", mem[5], 32'hBEEF0000);

        do_request(1'b0, 2'd2, 15'h0002, 32'h0, rc, er, ce);
        check_value("err_wmisalign_cycle", 32'(rc), 32'd1);
        check_value("err_wmisalign_flags", {30'd0, er, ce}, 32'd2);
        do_request(1'b1, 2'd1, 15'h0005, 32'h1234, rc, er, ce);
        check_value("err_hmisalign_cycle", 32'(rc), 32'd1);
        check_value("err_hmisalign_flags", {30'd0, er, ce}, 32'd2);
        check_value("err_hmisalign_mem", mem[1], 32'd0);
        do_request(1'b0, 2'd3, 15'h0000, 32'h0, rc, er, ce);
        check_value("err_size3_cycle", 32'(rc), 32'd1);
        check_value("err_size3_flags", {30'd0, er, ce}, 32'd2);
        do_request(1'b0, 2'd2, 15'h2000, 32'h0, rc, er, ce);
        check_value("err_range_cycle", 32'(rc), 32'd1);
        check_value("err_range_flags", {30'd0, er, ce}, 32'd2);
        check_value("err_dataread_kept", dataRead, 32'h00000033);

        do_request(1'b1, 2'd2, 15'h0020, 32'hA5A50001, rc, er, ce);
        do_request(1'b1, 2'd2, 15'h0024, 32'h0BADF00D, rc, er, ce);
        do_request(1'b1, 2'd2, 15'h0028, 32'hCAFE1234, rc, er, ce);
        check_value("b2b_store_cycle", 32'(rc), 32'd2);

        n_ready = 0;
        for (int k = 0; k < 15; k++) begin
            strobe = 1'b1; writeEnable = 1'b0; size = 2'd2;
            address = (k % 5 == 0) ? 15'(15'h0020 + 15'(4 * (k / 5))) : 15'(15'h0100 + 15'(4 * k));
            @(negedge clock);
            if (ready && n_ready < 3) begin
                ready_at[n_ready] = k;
                data_at[n_ready]  = dataRead;
                n_ready++;
            end
            @(posedge clock); #1;
        end
        strobe = 1'b0;
        check_value("b2b_ready_count", 32'(n_ready), 32'd3);
        if (n_ready == 3) begin
            check_value("b2b_ready0", 32'(ready_at[0]), 32'd4);
            check_value("b2b_gap1", 32'(ready_at[1] - ready_at[0]), 32'd5);
            check_value("b2b_gap2", 32'(ready_at[2] - ready_at[1]), 32'd5);
            check_value("b2b_data0", data_at[0], 32'hA5A50001);
            check_value("b2b_data1", data_at[1], 32'h0BADF00D);
            check_value("b2b_data2", data_at[2], 32'hCAFE1234);
        end
        @(posedge clock); #1;

        strobe = 1'b1; writeEnable = 1'b0; size = 2'd2; address = 15'h0028;
        @(posedge clock); #1;
        strobe = 1'b0;
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        check_value("midreset_ready_error", {30'd0, ready, error}, 32'd0);
        check_value("midreset_ce_wre", {30'd0, ramCe, ramWre}, 32'd0);
        check_value("midreset_dataread", dataRead, 32'd0);
        check_value("midreset_ramaddr", {21'd0, ramAddress}, 32'd0);
        check_value("midreset_ramdin", ramDataIn, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        do_request(1'b0, 2'd2, 15'h0024, 32'h0, rc, er, ce);
        check_value("postreset_cycle", 32'(rc), 32'd4);
        check_value("postreset_data", dataRead, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bsram_memory_adapter.md
# bsram_memory_adapter

- Memory-bus slave placed directly downstream of the RISC-V core's external memory bus.
- Converts byte-addressed byte/half/word requests into accesses to a single-port 32-bit Gowin block RAM.
- Handles lane alignment, read-modify-write for sub-word stores, and range and alignment checking.
- Completes each request with a one-cycle `ready` pulse and an optional `error` flag.

## Interface
Parameters:
- `ADDRESS_SIZE`, 15: bus byte-address width.
- `RAM_ADDRESS_SIZE`, 11: BSRAM word-address width (2048 x 32 = 8 KiB).
- `READ_LATENCY`, 2: BSRAM read latency. 1 = bypass mode, 2 = output-register mode. Other values are illegal.

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high.
- `strobe`  in  1  request valid.
- `address`  in  ADDRESS_SIZE  byte address.
- `size`  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `writeEnable`  in  1  1 = store, 0 = load.
- `dataWrite`  in  32  store data, right-aligned (low bits used).
- `dataRead`  out  32  load data, right-aligned, zero-extended.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  valid only with `ready`; the request was rejected.
- `ramAddress`  out  RAM_ADDRESS_SIZE  BSRAM `ad`.
- `ramDataIn`  out  32  BSRAM `din`.
- `ramDataOut`  in  32  BSRAM `dout`.
- `ramCe`, `ramWre`  out  1  BSRAM `ce` and `wre`.
- `ramOce`  out  1  constant 1.
- `ramReset`  out  1  constant 0.

## Operation
- **States:** IDLE, WRITE, READ_WAIT, MERGE, DONE.
- **IDLE accept:** with `strobe`=1, latch `address`, `size`, `writeEnable` and `dataWrite`. Input changes after the accept cycle are ignored.
- **Checks at accept:**
  - Error if `size`=3.
  - Error if half access with `address[0]`=1.
  - Error if word access with `address[1:0]`≠0.
  - Error if `address[ADDRESS_SIZE-1:2]` ≥ 2^RAM_ADDRESS_SIZE.
  - On error: go to DONE with `error`=1 and no RAM access. `dataRead` is unchanged.
- **Word store:** WRITE drives `ramCe`=`ramWre`=1, `ramDataIn`=data, then goes to DONE.
- **Load:** issue a read (`ramCe`=1, `ramWre`=0), then READ_WAIT for READ_LATENCY cycles.
  - Capture `dataRead` = `ramDataOut >> (8*address[1:0])`, masked to 8/16/32 bits.
  - Then go to DONE.
- **Sub-word store:** read the word, then MERGE replaces the addressed lane(s) with `dataWrite[7:0]` or `[15:0]` and writes the merged word back (`ramWre`=1). Then go to DONE.
- **DONE:** `ready`=1 for one cycle, then back to IDLE. A `strobe` sampled in the cycle after DONE is a new request.
- `ramAddress` = latched `address[RAM_ADDRESS_SIZE+1:2]`.
- `ramCe`=0 in IDLE and DONE. `ramWre`=1 only in WRITE or the MERGE write cycle.
- **`strobe` dropped mid-transaction:** ignored; the transaction completes.
- **Reset:**
  - Asynchronous; state goes to IDLE.
  - `ready`, `error`, `ramCe`, `ramWre` = 0; `dataRead`, `ramAddress`, `ramDataIn` = 0.
  - If reset hits a write cycle, the target word is unspecified; all other words are untouched.

## Timing
- Cycle 0 = the IDLE cycle in which `strobe`=1 is sampled.
- Error: `ready`+`error` in cycle 1.
- Word store: RAM write in cycle 1, `ready` in cycle 2.
- Load: RAM read in cycle 1, `ramDataOut` valid in cycle 1+L, `ready` in cycle 2+L. With L=2 that is cycle 4.
  - `dataRead` is valid from the `ready` cycle until the next load completes.
- Sub-word store: read in cycle 1, write in cycle 2+L, `ready` in cycle 3+L.
- **Back-to-back:** the requester updates or clears `strobe` at the edge where it samples `ready`. The next accept is earliest one cycle after `ready`.
- **Throughput (L=2):** word store every 3 cycles, load every 5 cycles.

## Test plan
- **Reset check:** reset asserted mid-READ_WAIT → all outputs 0 immediately; the next request is accepted normally.
- **Word store then load:** word store 0xDEADBEEF @0x0010, then word load @0x0010 → `ready` in cycles 2 and 4, `dataRead`=0xDEADBEEF, `error`=0.
- **Byte store:** byte store 0x5A @0x0013 over 0x11223344 → `ready` in cycle 5. A word load then returns 0x5A223344.
- **Sub-word loads:**
  - Half load @0x0012 of 0x5A223344 → 0x00005A22.
  - Byte load @0x0011 → 0x00000033.
- **Rejected requests:** each gets `ready`+`error` in cycle 1 with `ramCe` never asserted.
  - Word load @0x0002.
  - Half store @0x0005.
  - `size`=3.
  - Load @0x2000 (word index 2048, out of range).
- **Back-to-back and latching:** `strobe` held high across three loads, with `address` changed the cycle after accept → each completes with data from the latched address, and `ready` pulses are exactly 5 cycles apart (L=2).
